// File: rtl/irq_onehot_sequencer_if.sv
// Request/grant bundle between the IRQ sequencer and its producer/consumer side.
// The slave modport is the sequencer; the master side drives req/ack and observes the grant.
interface irq_onehot_sequencer_if;
    logic [7:0] req;
    logic       ack;
    logic       en;
    logic       Y7;
    logic       Y6;
    logic       Y5;
    logic       Y4;
    logic       Y3;
    logic       Y2;
    logic       Y1;
    logic       Y0;
    logic [7:0] pend;
    logic       overflow;
    logic       timeout;

    modport master (
        output req, ack,
        input  en, Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0, pend, overflow, timeout
    );

    modport slave (
        input  req, ack,
        output en, Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0, pend, overflow, timeout
    );
endinterface

// File: rtl/irq_onehot_sequencer.sv
// Captures request rising edges into a pending set and presents one grant at a time
// as a registered one-hot vector feeding the downstream 8-to-3 encoder.
module irq_onehot_sequencer #(
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 16
) (
    input logic                  clk,
    input logic                  rst,
    irq_onehot_sequencer_if.slave bus
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t           state_q, state_nxt;
    logic [7:0]       req_q, pend_q, y_q, y_nxt, req_edge, clr;
    logic             en_q, en_nxt, ovf_q, tmo_q, tmo_nxt, tmo_hit;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [2:0]       last_q, last_nxt;

    function automatic logic [2:0] onehot_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Round-robin visits last-1 down to last; the final overwrite is the closest candidate.
    function automatic logic [2:0] pick_winner(input logic [7:0] p, input logic [2:0] l);
        logic [2:0] w;
        logic [2:0] cand;
        w = '0;
        if (RR_MODE == 0) begin
            for (int i = 0; i < 8; i++) begin
                if (p[i]) w = 3'(i);
            end
        end else begin
            for (int k = 8; k >= 1; k--) begin
                cand = l - 3'(k);
                if (p[cand]) w = cand;
            end
        end
        return w;
    endfunction

    assign req_edge = bus.req & ~req_q;
    assign tmo_hit  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_nxt = state_q;
        y_nxt     = y_q;
        en_nxt    = en_q;
        cnt_nxt   = cnt_q;
        last_nxt  = last_q;
        tmo_nxt   = 1'b0;
        clr       = '0;
        case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    y_nxt     = 8'b1 << pick_winner(pend_q, last_q);
                    en_nxt    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end else begin
                    y_nxt  = '0;
                    en_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (bus.ack || tmo_hit) begin
                    clr       = y_q;
                    en_nxt    = 1'b0;
                    y_nxt     = '0;
                    tmo_nxt   = !bus.ack;
                    state_nxt = RELEASE;
                    if (RR_MODE != 0) last_nxt = onehot_index(y_q);
                end else if (cnt_q != CNT_MAX) begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                en_nxt    = 1'b0;
                y_nxt     = '0;
                state_nxt = IDLE;
            end
            default: begin
                en_nxt    = 1'b0;
                y_nxt     = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // req_q resets high so lines already asserted at reset release are not taken as edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 8'hFF;
            pend_q  <= '0;
            y_q     <= '0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            last_q  <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            req_q   <= bus.req;
            pend_q  <= (pend_q & ~clr) | req_edge;
            y_q     <= y_nxt;
            en_q    <= en_nxt;
            cnt_q   <= cnt_nxt;
            last_q  <= last_nxt;
            ovf_q   <= |(req_edge & pend_q & ~clr);
            tmo_q   <= tmo_nxt;
        end
    end

    assign bus.en       = en_q;
    assign bus.Y7       = y_q[7];
    assign bus.Y6       = y_q[6];
    assign bus.Y5       = y_q[5];
    assign bus.Y4       = y_q[4];
    assign bus.Y3       = y_q[3];
    assign bus.Y2       = y_q[2];
    assign bus.Y1       = y_q[1];
    assign bus.Y0       = y_q[0];
    assign bus.pend     = pend_q;
    assign bus.overflow = ovf_q;
    assign bus.timeout  = tmo_q;
endmodule

// File: tb/tb_irq_onehot_sequencer.sv
// Bench for irq_onehot_sequencer: a fixed-priority and a round-robin instance run side by side
// against a transaction-level reference model through per-instance expectation queues.
module tb_irq_onehot_sequencer;
    localparam int TMO = 16;

    typedef struct packed {
        logic [7:0] pend;
        logic       en;
        logic [7:0] y;
        logic       ovf;
        logic       tmo;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    irq_onehot_sequencer_if if0 ();
    irq_onehot_sequencer_if if1 ();

    irq_onehot_sequencer #(.RR_MODE(0), .TIMEOUT(TMO)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    irq_onehot_sequencer #(.RR_MODE(1), .TIMEOUT(TMO)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    logic [1:0] en_w, ovf_w, tmo_w;
    logic [7:0] y_w [2];
    logic [7:0] pend_w [2];
    assign en_w     = {if1.en, if0.en};
    assign ovf_w    = {if1.overflow, if0.overflow};
    assign tmo_w    = {if1.timeout, if0.timeout};
    assign y_w[0]   = {if0.Y7, if0.Y6, if0.Y5, if0.Y4, if0.Y3, if0.Y2, if0.Y1, if0.Y0};
    assign y_w[1]   = {if1.Y7, if1.Y6, if1.Y5, if1.Y4, if1.Y3, if1.Y2, if1.Y1, if1.Y0};
    assign pend_w[0] = if0.pend;
    assign pend_w[1] = if1.pend;

    int n_checks = 0;
    int n_errors = 0;

    rec_t q0[$];
    rec_t q1[$];
    int   glog0[$];
    int   glog1[$];

    // Reference model state: pending set, current grant (-1 none), hold time, gap flag, RR pointer.
    logic [7:0] m_pend [2];
    logic [7:0] m_reqq [2];
    int         m_g    [2];
    int         m_held [2];
    bit         m_gap  [2];
    int         m_last [2];

    int ack_pol = 0;
    int ack_pct = 30;

    task automatic chk(input bit ok, input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic int model_winner(input int m, input logic [7:0] p, input int last);
        int idx;
        if (m == 0) begin
            for (int i = 7; i >= 0; i--) if (p[i]) return i;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                idx = (last - k + 8) % 8;
                if (p[idx]) return idx;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0;
            m_reqq[m] = 8'hFF;
            m_g[m]    = -1;
            m_held[m] = 0;
            m_gap[m]  = 1'b0;
            m_last[m] = 0;
        end
    endtask

    task automatic model_step(input int m, input logic [7:0] r, input logic a);
        logic [7:0] e, clr;
        rec_t rec;
        bit tmo;
        e   = r & ~m_reqq[m];
        clr = '0;
        tmo = 1'b0;
        if (m_g[m] >= 0) begin
            if (a || m_held[m] == TMO - 1) begin
                tmo = !a;
                clr = 8'(1) << m_g[m];
                if (m == 1) m_last[m] = m_g[m];
                m_g[m]   = -1;
                m_gap[m] = 1'b1;
            end else begin
                m_held[m]++;
            end
        end else if (m_gap[m]) begin
            m_gap[m] = 1'b0;
        end else if (m_pend[m] != '0) begin
            m_g[m]    = model_winner(m, m_pend[m], m_last[m]);
            m_held[m] = 0;
        end
        rec.ovf   = |(e & m_pend[m] & ~clr);
        m_pend[m] = (m_pend[m] & ~clr) | e;
        m_reqq[m] = r;
        rec.pend  = m_pend[m];
        rec.en    = (m_g[m] >= 0);
        rec.y     = (m_g[m] >= 0) ? (8'(1) << m_g[m]) : 8'h00;
        rec.tmo   = tmo;
        if (m == 0) q0.push_back(rec);
        else        q1.push_back(rec);
    endtask

    task automatic tick(input logic [7:0] r, input logic man_ack);
        logic a [2];
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            case (ack_pol)
                0:       a[m] = 1'b0;
                1:       a[m] = (m_g[m] >= 0);
                2:       a[m] = ($urandom_range(99) < ack_pct);
                default: a[m] = man_ack;
            endcase
        end
        if0.req = r;
        if1.req = r;
        if0.ack = a[0];
        if1.ack = a[1];
        for (int m = 0; m < 2; m++) model_step(m, r, a[m]);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk({en_w[m], y_w[m], pend_w[m], ovf_w[m], tmo_w[m]} == '0, tag,
                {en_w[m], y_w[m], pend_w[m], ovf_w[m], tmo_w[m]}, 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_zero("reset_outputs");
        q0.delete();
        q1.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    // Monitor: one expectation per instance per clock while out of reset.
    task automatic check_one(input int m);
        rec_t got, exp;
        got.pend = pend_w[m];
        got.en   = en_w[m];
        got.y    = y_w[m];
        got.ovf  = ovf_w[m];
        got.tmo  = tmo_w[m];
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            chk(1'b0, (m == 0) ? "dut0_unexpected_cycle" : "dut1_unexpected_cycle", got, 0);
        end else begin
            exp = (m == 0) ? q0.pop_front() : q1.pop_front();
            chk(got == exp, (m == 0) ? "dut0_outputs" : "dut1_outputs", got, exp);
        end
    endtask

    initial begin
        logic [1:0] prev_en;
        prev_en = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_en = '0;
            end else begin
                for (int m = 0; m < 2; m++) begin
                    check_one(m);
                    if (en_w[m] && !prev_en[m]) begin
                        for (int i = 0; i < 8; i++) begin
                            if (y_w[m][i]) begin
                                if (m == 0) glog0.push_back(i);
                                else        glog1.push_back(i);
                            end
                        end
                    end
                end
                prev_en = en_w;
            end
        end
    end

    int exp_order [10] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 0};
    int exp_fixed [2]  = '{5, 2};
    int en_cnt [2];
    int ev_cnt [2];

    initial begin
        if0.req = '0; if0.ack = 1'b0;
        if1.req = '0; if1.ack = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Single request on bit 7, acked immediately, level held afterwards.
        ack_pol = 1;
        tick(8'h00, 1'b0);
        tick(8'h80, 1'b0);
        for (int m = 0; m < 2; m++) chk(pend_w[m] == 8'h80 && !en_w[m], "t1_pend", {en_w[m], pend_w[m]}, 9'h080);
        tick(8'h80, 1'b0);
        for (int m = 0; m < 2; m++) chk(en_w[m] && y_w[m] == 8'h80, "t1_grant", {en_w[m], y_w[m]}, 9'h180);
        tick(8'h80, 1'b0);
        for (int m = 0; m < 2; m++) chk(!en_w[m] && pend_w[m] == 8'h00, "t1_ack", {en_w[m], pend_w[m]}, 9'h000);
        repeat (4) tick(8'h80, 1'b0);
        for (int m = 0; m < 2; m++) chk(!en_w[m], "t1_no_regrant", en_w[m], 0);

        // Two simultaneous requests: bit 5 then bit 2.
        glog0.delete(); glog1.delete();
        tick(8'h00, 1'b0);
        repeat (10) tick(8'h24, 1'b0);
        chk(glog0.size() == 2 && glog0[0] == exp_fixed[0] && glog0[1] == exp_fixed[1], "t2_order_fixed",
            glog0.size(), 2);
        for (int m = 0; m < 2; m++) chk(pend_w[m] == 8'h00 && !en_w[m], "t2_idle", {en_w[m], pend_w[m]}, 0);

        // All eight at once after reset, then bits 7 and 0 again.
        do_reset();
        glog0.delete(); glog1.delete();
        tick(8'h00, 1'b0);
        repeat (30) tick(8'hFF, 1'b0);
        tick(8'h00, 1'b0);
        repeat (10) tick(8'h81, 1'b0);
        chk(glog1.size() == 10, "t3_rr_count", glog1.size(), 10);
        chk(glog0.size() == 10, "t3_fixed_count", glog0.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < glog1.size()) chk(glog1[i] == exp_order[i], "t3_rr_order", glog1[i], exp_order[i]);
            if (i < glog0.size()) chk(glog0[i] == exp_order[i], "t3_fixed_order", glog0[i], exp_order[i]);
        end

        // Timeout: never acked, grant released after exactly TMO cycles.
        ack_pol = 0;
        en_cnt = '{0, 0};
        ev_cnt = '{0, 0};
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        for (int t = 0; t < 25; t++) begin
            tick((t == 0) ? 8'h08 : 8'h00, 1'b0);
            for (int m = 0; m < 2; m++) begin
                en_cnt[m] += int'(en_w[m]);
                ev_cnt[m] += int'(tmo_w[m]);
            end
        end
        for (int m = 0; m < 2; m++) begin
            chk(en_cnt[m] == TMO, "t4_hold_cycles", en_cnt[m], TMO);
            chk(ev_cnt[m] == 1, "t4_timeout_pulses", ev_cnt[m], 1);
            chk(pend_w[m] == 8'h00 && !en_w[m], "t4_released", {en_w[m], pend_w[m]}, 0);
        end

        // Re-edge on the bit being acked, then a double edge on a pending bit.
        ack_pol = 3;
        tick(8'h00, 1'b0);
        tick(8'h10, 1'b0);
        tick(8'h10, 1'b0);
        tick(8'h00, 1'b0);
        tick(8'h10, 1'b1);
        for (int m = 0; m < 2; m++)
            chk(pend_w[m] == 8'h10 && !ovf_w[m] && !en_w[m], "t5_set_wins", {ovf_w[m], en_w[m], pend_w[m]}, 10'h010);
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        for (int m = 0; m < 2; m++) chk(en_w[m] && y_w[m] == 8'h10, "t5_regrant", {en_w[m], y_w[m]}, 9'h110);
        ev_cnt = '{0, 0};
        tick(8'h02, 1'b0); for (int m = 0; m < 2; m++) ev_cnt[m] += int'(ovf_w[m]);
        tick(8'h00, 1'b0); for (int m = 0; m < 2; m++) ev_cnt[m] += int'(ovf_w[m]);
        tick(8'h02, 1'b0); for (int m = 0; m < 2; m++) ev_cnt[m] += int'(ovf_w[m]);
        tick(8'h00, 1'b0); for (int m = 0; m < 2; m++) ev_cnt[m] += int'(ovf_w[m]);
        for (int m = 0; m < 2; m++) chk(ev_cnt[m] == 1, "t5_overflow_pulses", ev_cnt[m], 1);
        ack_pol = 1;
        repeat (10) tick(8'h00, 1'b0);

        // Asynchronous reset in the middle of a grant with another request pending.
        ack_pol = 0;
        tick(8'h00, 1'b0);
        tick(8'h20, 1'b0);
        tick(8'h24, 1'b0);
        for (int m = 0; m < 2; m++) chk(en_w[m] && pend_w[m] == 8'h24, "t6_pre_reset", {en_w[m], pend_w[m]}, 9'h124);
        if0.req = 8'h01;
        if1.req = 8'h01;
        #3;
        do_reset();
        ack_pol = 1;
        repeat (4) tick(8'h01, 1'b0);
        for (int m = 0; m < 2; m++) chk(!en_w[m] && pend_w[m] == 8'h00, "t6_held_level", {en_w[m], pend_w[m]}, 0);
        tick(8'h00, 1'b0);
        tick(8'h01, 1'b0);
        tick(8'h01, 1'b0);
        for (int m = 0; m < 2; m++) chk(en_w[m] && y_w[m] == 8'h01, "t6_new_edge", {en_w[m], y_w[m]}, 9'h101);

        // Randomized traffic with random acks; slow-ack phase exercises timeouts.
        ack_pol = 2;
        begin
            logic [7:0] r;
            r = 8'h00;
            for (int t = 0; t < 3000; t++) begin
                ack_pct = (t < 1500) ? 35 : 4;
                r = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
                tick(r, 1'b0);
            end
        end
        ack_pol = 1;
        repeat (40) tick(8'h00, 1'b0);

        #2;
        chk(q0.size() == 0 && q1.size() == 0, "queues_drained", q0.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/irq_onehot_sequencer.md
Name: irq_onehot_sequencer

Overview:
- Upstream stage of the 8-to-3 encoder.
- Captures rising edges on 8 request lines into a pending register and grants one request at a time.
- Drives the encoder's en and Y7..Y0 inputs with a registered, strictly one-hot vector.
- Holds each grant until the consumer acks or a timeout expires, so the encoder's 3-bit code stays stable while valid.

Parameters:
- RR_MODE, 0, arbitration: 0 = fixed priority (bit 7 highest), 1 = round-robin.
- TIMEOUT, 16, cycles a grant is held without ack before forced release; 0 disables the timeout (wait forever).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  8  request lines, level; only rising edges register a request.
- ack  input  1  consumer has taken the current code; sampled only in GRANT.
- en  output  1  grant valid; drives encoder en.
- Y7..Y0  output  1 each  one-hot granted request; drives encoder Y7..Y0; all 0 when en=0.
- pend  output  8  pending-request register.
- overflow  output  1  one-cycle pulse: an edge arrived on a bit already pending.
- timeout  output  1  one-cycle pulse: a grant was released by timeout.

Behaviour:
- Reset (async, immediate on rst high):
  - en=0, Y7..Y0=0, pend=0, overflow=0, timeout=0.
  - State IDLE, grant counter=0, RR pointer last=0.
  - Edge-detect register req_q=8'hFF, so levels already high when reset releases are not captured.
- Edge detect: edge = req & ~req_q, evaluated each cycle; req_q <= req every cycle.
- Pending update each cycle: pend <= (pend & ~clr) | edge.
  - clr is the granted bit on the ack or timeout cycle, else 0.
  - Set wins: an edge on the bit being cleared in the same cycle leaves that bit pending.
- overflow = registered OR of (edge & pend & ~clr).
  - The request is merged and not counted.
  - pend is unchanged for that bit.
- FSM states IDLE, GRANT, RELEASE; all outputs registered.
- IDLE:
  - If pend != 0, select a winner, load Y with its one-hot, set en=1, clear the counter, go to GRANT.
  - Otherwise stay in IDLE with outputs 0.
- GRANT:
  - Y and en are held constant.
  - If ack=1: clr = granted bit; en=0, Y=0; if RR_MODE, last = granted index; go to RELEASE.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: same actions as ack, plus a timeout pulse.
  - Else counter += 1. The counter is 5 bits wide (sized to TIMEOUT) and saturates.
- RELEASE: one cycle with en=0, Y=0 (guaranteed gap between grants); then go to IDLE.
- Winner selection:
  - Fixed priority: highest set index of pend.
  - Round-robin: search last-1, last-2, …, wrapping 0→7, ending with last; first set bit wins. After reset the search therefore starts at 7.
- Latency:
  - req rises before edge k → pend bit visible after edge k.
  - If IDLE at edge k+1, en/Y are visible after edge k+1.
  - ack sampled at edge m → en=0 after m; next grant earliest after edge m+2.
- en=1 implies exactly one Y bit is set; en=0 implies all Y bits are 0.
- Edges arriving during GRANT/RELEASE are captured and do not disturb the current grant.
- ack outside GRANT is ignored.
- Reset mid-grant drops the grant and all pending requests with no ack required.

Test Plan:
- Reset, then req=8'h80 held → pend=8'h80 after 1 edge; en=1, Y7=1 after 2 edges (encoder A=3'b111). ack one cycle → en=0, pend=0; one RELEASE cycle; req held high creates no new grant.
- RR_MODE=0, req 8'h00→8'h24 in one cycle → grant Y5 first; ack → grant Y2 after one-cycle gap; ack → IDLE, pend=0.
- RR_MODE=1, req=8'hFF edge, ack every grant → grant order 7,6,5,4,3,2,1,0; re-pulse bit 7 and bit 0 after last=0 → order 7 then 0.
- TIMEOUT=16, grant bit 3, ack held 0 → en stays 1 for exactly 16 cycles; timeout pulses once; pend bit 3 cleared; en=0.
- During a grant on bit 4, pulse bit 4 again on the ack cycle → pend bit 4 remains 1, overflow=0, bit 4 re-granted. Pulse bit 1 twice while it is pending → overflow pulses once.
- Assert rst mid-GRANT (async, between edges) → en, Y, pend, timeout go 0 immediately. Release with req=8'h01 held → no grant until req falls and rises again.
